nixie_display_arbiter: RTL
==========================

# nixie_display_arbiter

Shares the 8-digit seven-segment display between three content sources (status/idle, menu/song info, alert) and drives the 48-bit character bus of the tube driver. Each source presents a full 8-character frame of 6-bit character codes plus a request. The block grants the display by fixed priority, with a minimum on-screen hold time so short messages stay readable. It outputs a registered frame for the tube driver's `in` port.

## Interface
- `HOLD_CYCLES`, default 24'd5000000: minimum display time after a grant, in `sys_clk` cycles. Legal range is 1 to 2^24−1.
- `BLANK_CODE`, default 6'b100000: character code the tube driver renders as blank.
- `sys_clk`  in  1  system clock. The only clock.
- `sys_rest`  in  1  asynchronous, active-low reset.
- `req`  in  3  request per source. Bit 2 has the highest priority, bit 0 the lowest.
- `frame0`  in  48  source 0 frame. Digit 0 is at [5:0] and digit 7 at [47:42].
- `frame1`  in  48  source 1 frame, same packing.
- `frame2`  in  48  source 2 frame, same packing.
- `frame_out`  out  48  registered frame to the tube driver.
- `grant`  out  3  one-hot current owner. 3'b000 means no owner.
- `switch_pulse`  out  1  high for exactly one cycle after any change of `grant`.

## Operation
- Blank frame: `{8{BLANK_CODE}}`, which is 48'h820820820820 at the default value.
- States:
  - IDLE: no owner.
  - OWN: owner is granted and still requesting.
  - LINGER: owner has dropped `req` while its hold is still running.
- Hold counter:
  - 24 bits.
  - Loaded with `HOLD_CYCLES-1` on every new grant, including a preemption.
  - Decrements by 1 each cycle while nonzero and saturates at 0.
  - `hold_done` means counter == 0, evaluated in the current cycle.
- Winner: the highest-indexed asserted `req` bit.
- "Higher" means a request with a higher index than the current owner.
- IDLE:
  - Any `req` asserted: grant the winner, `frame_out` <= winner's frame, load counter, go to OWN.
  - Otherwise: stay in IDLE with `frame_out` blank.
- OWN: `frame_out` <= owner's frame every cycle (live tracking). Cases in priority order:
  1. Higher request present: preempt. Grant the higher winner, load counter, stay in OWN.
  2. Owner `req` low and `hold_done`, with another request present: grant the winner, load counter.
  3. Owner `req` low and `hold_done`, with no request: `grant` <= 0, `frame_out` <= blank, go to IDLE.
  4. Owner `req` low and hold not done: go to LINGER. `frame_out` keeps the last value it captured.
  5. Otherwise: hold the owner. A lower request never displaces an owner that is still requesting, even after `hold_done`.
- LINGER: `frame_out` is frozen and `grant` is unchanged. Cases in priority order:
  1. Higher request present: preempt, as in OWN.
  2. Owner re-asserts `req`: return to OWN. The counter is not reloaded.
  3. `hold_done`: release, exactly as in OWN cases 2 and 3.
- Simultaneous events:
  - Preemption beats release and beats re-assert.
  - Owner drop in the same cycle as a higher request: preempt, no LINGER.
- `switch_pulse` is registered. It is asserted in the cycle after the edge on which `grant` changed value. This includes changes to and from 3'b000.
- Frames of non-owners are ignored. Any 6-bit code passes through unmodified.

## Timing
- Reset (asynchronous, on `sys_rest` low):
  - `grant` = 0, `frame_out` = blank, `switch_pulse` = 0.
  - State = IDLE, counter = 0.
  - Release is synchronous to `sys_clk`.
- A `req` sampled high at edge N yields `grant` and `frame_out` valid after edge N.
  - Latency is one clock.
- `switch_pulse` goes high after edge N+1 and low after edge N+2.
- A `frame_out` change from the owner's source appears one clock after the source changes.
- With `HOLD_CYCLES`=H, an owner that drops `req` right after its grant keeps the display for H cycles after the grant edge. Release happens on the first edge where `hold_done` is seen.
- With H=1, the counter loads 0, so release on drop is immediate, one cycle after the drop is sampled.
- Reset asserted mid-operation (OWN or LINGER) returns every output to its reset value immediately. No residual grant or frame remains.

## Test plan
- Reset: hold `sys_rest` low with random `req`/frames, then release.
  - Required: `frame_out`=48'h820820820820, `grant`=000, `switch_pulse`=0 until the first request.
- Single grant (H=4): `req`=001 from cycle 0, `frame0`=48'h123456789ABC.
  - Required: `grant`=001 and `frame_out`=48'h123456789ABC after edge 1.
  - Required: `switch_pulse` high for exactly one cycle after edge 2.
- Preemption (H=100): source 0 owns, then `req`[2] rises for one cycle only.
  - Required: `grant`=100 and `frame_out`=`frame2` on the next edge.
  - Required: display stays on source 2 for 100 cycles in LINGER, then returns to source 0 if `req`[0] is still high.
- Linger (H=4): `req`=010 for one cycle, then `frame1` changes and `req`=000.
  - Required: `frame_out` frozen at the first `frame1` value.
  - Required: `grant`=010 for 4 cycles after the grant edge, then `grant`=000 and blank.
- Release to lower and no starvation-preemption (H=4): `req`=011 held for 20 cycles.
  - Required: `grant` stays 010 throughout.
  - Then drop `req`[1]: required `grant`=001 on the next edge.
- Reset mid-LINGER: assert `sys_rest` low in cycle 2 of a linger.
  - Required: outputs are at reset values immediately.
  - Required: after release with `req`=100, `grant`=100 after one edge.

Source files
------------

// File: rtl/nixie_display_arbiter.sv
// Fixed-priority arbiter sharing the 8-digit tube display between three frame sources,
// with a minimum on-screen hold after each grant and a registered 48-bit frame output.
module nixie_display_arbiter #(
  parameter logic [23:0] HOLD_CYCLES = 24'd5000000,
  parameter logic [5:0]  BLANK_CODE  = 6'b100000
) (
  input  logic        sys_clk,
  input  logic        sys_rest,
  input  logic [2:0]  req,
  input  logic [47:0] frame0,
  input  logic [47:0] frame1,
  input  logic [47:0] frame2,
  output logic [47:0] frame_out,
  output logic [2:0]  grant,
  output logic        switch_pulse
);

  localparam logic [1:0]  S_IDLE    = 2'd0;
  localparam logic [1:0]  S_OWN     = 2'd1;
  localparam logic [1:0]  S_LINGER  = 2'd2;
  localparam logic [47:0] BLANK     = {8{BLANK_CODE}};
  localparam logic [23:0] HOLD_LOAD = HOLD_CYCLES - 24'd1;

  logic [1:0]       state, state_nxt;
  logic [23:0]      cnt;
  logic [2:0]       grant_nxt, grant_prev, win_oh, above;
  logic [47:0]      frame_nxt, win_frame, own_frame;
  logic [2:0][47:0] frames;
  logic             load, hold_done, higher_req, owner_req, any_req;

  assign frames     = {frame2, frame1, frame0};
  assign hold_done  = (cnt == 24'd0);
  assign any_req    = |req;
  assign owner_req  = |(req & grant);
  assign higher_req = |(req & above);

  always_comb begin
    win_oh = 3'b000;
    if (req[2])      win_oh = 3'b100;
    else if (req[1]) win_oh = 3'b010;
    else if (req[0]) win_oh = 3'b001;
  end

  // Sources strictly above the current owner; with no owner nothing counts as "higher".
  always_comb begin
    case (grant)
      3'b001:  above = 3'b110;
      3'b010:  above = 3'b100;
      default: above = 3'b000;
    endcase
  end

  always_comb begin
    win_frame = BLANK;
    own_frame = BLANK;
    for (int i = 0; i < 3; i++) begin
      if (win_oh[i]) win_frame = frames[i];
      if (grant[i])  own_frame = frames[i];
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    frame_nxt = frame_out;
    load      = 1'b0;
    case (state)
      S_IDLE: begin
        if (any_req) begin
          state_nxt = S_OWN;
          grant_nxt = win_oh;
          frame_nxt = win_frame;
          load      = 1'b1;
        end else begin
          frame_nxt = BLANK;
        end
      end
      S_OWN, S_LINGER: begin
        if (higher_req) begin
          state_nxt = S_OWN;
          grant_nxt = win_oh;
          frame_nxt = win_frame;
          load      = 1'b1;
        end else if (owner_req) begin
          // Re-assert from LINGER keeps the frozen frame for this edge; live tracking resumes next cycle.
          state_nxt = S_OWN;
          if (state == S_OWN) frame_nxt = own_frame;
        end else if (hold_done) begin
          if (any_req) begin
            state_nxt = S_OWN;
            grant_nxt = win_oh;
            frame_nxt = win_frame;
            load      = 1'b1;
          end else begin
            state_nxt = S_IDLE;
            grant_nxt = 3'b000;
            frame_nxt = BLANK;
          end
        end else begin
          state_nxt = S_LINGER;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        grant_nxt = 3'b000;
        frame_nxt = BLANK;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rest) begin
    if (!sys_rest) begin
      state        <= S_IDLE;
      cnt          <= 24'd0;
      grant        <= 3'b000;
      grant_prev   <= 3'b000;
      frame_out    <= BLANK;
      switch_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      frame_out  <= frame_nxt;
      grant_prev <= grant;
      // Pulse trails the grant edge by one cycle: compares the registered grant with its previous value.
      switch_pulse <= (grant != grant_prev);
      if (load)                cnt <= HOLD_LOAD;
      else if (cnt != 24'd0)   cnt <= cnt - 24'd1;
    end
  end

endmodule
